// File: rtl/ud_count_scheduler.sv
// Round-robin scheduler sharing one up/down counter between an up-requester
// and a down-requester. A granted job drives cnt_en/cnt_ud for exactly the
// requested number of steps. Without wrap, a job stops early at the boundary.
module ud_count_scheduler #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned STEPW   = 4,
  parameter bit          WRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_up,
  input  logic [STEPW-1:0] step_up,
  output logic             gnt_up,
  output logic             done_up,
  input  logic             req_dn,
  input  logic [STEPW-1:0] step_dn,
  output logic             gnt_dn,
  output logic             done_dn,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_ud,
  output logic             sat,
  output logic [STEPW-1:0] steps_done,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;          // 1 = job counts up
  logic             last_up_q, last_up_d;  // 1 = up side served last
  logic [STEPW-1:0] rem_q, rem_d;
  logic [STEPW-1:0] steps_done_q, steps_done_d;
  logic             sat_pend_q, sat_pend_d;
  logic             gnt_up_q, gnt_up_d;
  logic             gnt_dn_q, gnt_dn_d;
  logic             cnt_ud_q, cnt_ud_d;    // direction held outside RUN
  logic             sel_up, sel_dn, blk;

  // State and job registers; reset leaves last_srv = down so up wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      dir_q        <= 1'b0;
      last_up_q    <= 1'b0;
      rem_q        <= '0;
      steps_done_q <= '0;
      sat_pend_q   <= 1'b0;
      gnt_up_q     <= 1'b0;
      gnt_dn_q     <= 1'b0;
      cnt_ud_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      last_up_q    <= last_up_d;
      rem_q        <= rem_d;
      steps_done_q <= steps_done_d;
      sat_pend_q   <= sat_pend_d;
      gnt_up_q     <= gnt_up_d;
      gnt_dn_q     <= gnt_dn_d;
      cnt_ud_q     <= cnt_ud_d;
    end
  end

  // Arbitration, step accounting and per-state outputs.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    last_up_d    = last_up_q;
    rem_d        = rem_q;
    steps_done_d = steps_done_q;
    sat_pend_d   = sat_pend_q;
    cnt_ud_d     = cnt_ud_q;
    gnt_up_d     = 1'b0;
    gnt_dn_d     = 1'b0;
    cnt_en       = 1'b0;
    done_up      = 1'b0;
    done_dn      = 1'b0;
    sat          = 1'b0;
    sel_up       = 1'b0;
    sel_dn       = 1'b0;
    blk          = 1'b0;

    unique case (state_q)
      StIdle: begin
        sel_up = req_up & (~req_dn | ~last_up_q);
        sel_dn = req_dn & (~req_up | last_up_q);
        if (sel_up || sel_dn) begin
          dir_d        = sel_up;
          rem_d        = sel_up ? step_up : step_dn;
          steps_done_d = '0;
          sat_pend_d   = 1'b0;
          gnt_up_d     = sel_up;
          gnt_dn_d     = sel_dn;
          state_d      = (rem_d == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        cnt_ud_d = dir_q;
        blk = !WRAP_EN && (dir_q ? (cnt_q == {WIDTH{1'b1}}) : (cnt_q == '0));
        if (blk) begin
          sat_pend_d = 1'b1;
          state_d    = StDone;
        end else begin
          cnt_en       = 1'b1;
          rem_d        = rem_q - STEPW'(1);
          steps_done_d = steps_done_q + STEPW'(1);
          if (rem_q == STEPW'(1)) state_d = StDone;
        end
      end
      StDone: begin
        done_up    = dir_q;
        done_dn    = ~dir_q;
        sat        = sat_pend_q;
        last_up_d  = dir_q;
        sat_pend_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign gnt_up     = gnt_up_q;
  assign gnt_dn     = gnt_dn_q;
  assign cnt_ud     = (state_q == StRun) ? dir_q : cnt_ud_q;
  assign steps_done = steps_done_q;
  assign busy       = (state_q != StIdle);

endmodule
